// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: requester-side controller for a combinational 64-bit ALU.
//   Upstream : in_valid/in_ready handshake carrying class/funct fields, operands and a tag.
//   ALU side : alu_a/alu_b/alu_op driven from registers, alu_result sampled one cycle later.
//   Downstream: out_valid/out_ready handshake returning result, zero flag, illegal flag, tag.
//   Status   : ops_done (wrapping count of responses), illegal_cnt (saturating count of
//              accepted illegal requests).
module alu_issue_ctrl #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TAGW    = 4,
  parameter int unsigned OPSCNTW = 32,
  parameter int unsigned ILLCNTW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_class,
  input  logic [2:0]         in_funct3,
  input  logic               in_funct7b5,
  input  logic [XLEN-1:0]    in_a,
  input  logic [XLEN-1:0]    in_b,
  input  logic [TAGW-1:0]    in_tag,
  output logic [XLEN-1:0]    alu_a,
  output logic [XLEN-1:0]    alu_b,
  output logic [3:0]         alu_op,
  input  logic [XLEN-1:0]    alu_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic               out_zero,
  output logic               out_illegal,
  output logic [TAGW-1:0]    out_tag,
  output logic [OPSCNTW-1:0] ops_done,
  output logic [ILLCNTW-1:0] illegal_cnt
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpNor = 4'b1100;
  localparam logic [3:0] OpSll = 4'b1000;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q, state_d;

  logic [3:0]      dec_op;
  logic            dec_ill;
  logic [XLEN-1:0] dec_b;
  logic            accept;
  logic            out_fire;
  logic            ill_q;
  logic [TAGW-1:0] tag_q;

  // Instruction decode
  always_comb begin
    dec_op  = OpAnd;
    dec_ill = 1'b0;
    case (in_class)
      2'b00: dec_op = OpAdd;
      2'b01: dec_op = OpSub;
      2'b10: begin
        case (in_funct3)
          3'b000:  dec_op = in_funct7b5 ? OpSub : OpAdd;
          3'b111:  dec_op = OpAnd;
          3'b110:  dec_op = OpOr;
          3'b001:  if (!in_funct7b5) dec_op = OpSll; else dec_ill = 1'b1;
          3'b100:  if (in_funct7b5) dec_op = OpNor; else dec_ill = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
      default: begin
        case (in_funct3)
          3'b000:  dec_op = OpAdd;
          3'b111:  dec_op = OpAnd;
          3'b110:  dec_op = OpOr;
          3'b001:  if (!in_funct7b5) dec_op = OpSll; else dec_ill = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
    endcase
    // Shift amount masked to 0..63 at latch time so alu_b is already clean in EXEC
    dec_b = (dec_op == OpSll && !dec_ill) ? {{(XLEN-6){1'b0}}, in_b[5:0]} : in_b;
  end

  // Next-state and handshake signals
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StExec;
      end
      StExec: state_d = StResp;
      StResp: begin
        // Consuming the response frees the latches, so a new request may enter the same edge
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? StExec : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign out_fire  = (state_q == StResp) & out_ready;
  assign out_valid = (state_q == StResp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= OpAnd;
      ill_q       <= 1'b0;
      tag_q       <= '0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
      out_tag     <= '0;
      ops_done    <= '0;
      illegal_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a  <= in_a;
        alu_b  <= dec_b;
        alu_op <= dec_ill ? OpAnd : dec_op;
        ill_q  <= dec_ill;
        tag_q  <= in_tag;
        if (dec_ill && !(&illegal_cnt)) illegal_cnt <= illegal_cnt + 1'b1;
      end
      if (state_q == StExec) begin
        out_result  <= ill_q ? '0 : alu_result;
        out_zero    <= (alu_result == '0) & ~ill_q;
        out_illegal <= ill_q;
        out_tag     <= tag_q;
      end
      if (out_fire) ops_done <= ops_done + 1'b1;
    end
  end

endmodule
